// File: rtl/gamedata_line_scanner_pkg.sv
// Shared widths, type codes, FSM states and entry layout for the gamedata line scanner.
// Optional build macro used by the scanner: GAMEDATA_COLLIDE_EN.
package gamedata_line_scanner_pkg;

   localparam int TYPE_W    = 4;
   localparam int X_W       = 10;
   localparam int Y_W       = 10;
   localparam int W_W       = 8;
   localparam int H_W       = 8;
   localparam int OBJ_COUNT = 8;
   localparam int SLOTS     = 4;

   localparam int DATA_LEN = TYPE_W + X_W + Y_W + W_W + H_W;
   localparam int GD_W     = OBJ_COUNT * DATA_LEN;
   localparam int IDX_W    = (OBJ_COUNT > 1) ? $clog2(OBJ_COUNT) : 1;
   localparam int CNT_W    = $clog2(SLOTS + 1);

   localparam logic [TYPE_W-1:0] TYPE_END      = '0;
   localparam logic [TYPE_W-1:0] TYPE_DINO     = TYPE_W'(1);
   localparam logic [TYPE_W-1:0] TYPE_OBSTACLE = TYPE_W'(2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   // Packed MSB-first, so the type field lands at the entry LSB.
   typedef struct packed {
      logic [H_W-1:0]    h;
      logic [W_W-1:0]    w;
      logic [Y_W-1:0]    y;
      logic [X_W-1:0]    x;
      logic [TYPE_W-1:0] typ;
   } obj_t;

   // Vertical overlap; the end row is formed one bit wider so y+height never wraps.
   function automatic logic line_overlap(obj_t o, logic [Y_W-1:0] ly);
      logic [Y_W:0] y_end;
      y_end = {1'b0, o.y} + {{(Y_W + 1 - H_W){1'b0}}, o.h};
      return (o.y <= ly) && ({1'b0, ly} < y_end);
   endfunction

endpackage

// File: rtl/gamedata_line_scanner_if.sv
// Line-scan and pixel-query bus between the game/VGA side (master) and the scanner (slave).
interface gamedata_line_scanner_if;
   import gamedata_line_scanner_pkg::*;

   // line_start and pix_valid are single-cycle strobes with no backpressure: the scanner
   // accepts every strobe. line_ready is a level; hit_valid pulses exactly one cycle after
   // each accepted pix_valid, and the other hit_* fields hold between responses.
   logic [GD_W-1:0]   gamedata;
   logic              line_start;
   logic [Y_W-1:0]    line_y;
   logic              line_ready;
   logic              pix_valid;
   logic [X_W-1:0]    pix_x;
   logic              hit_valid;
   logic              hit;
   logic [TYPE_W-1:0] hit_type;
   logic [W_W-1:0]    hit_u;
   logic [H_W-1:0]    hit_v;
   logic              overflow;
   logic              collide;
   state_t            dbg_state;

   modport master (
      output gamedata, line_start, line_y, pix_valid, pix_x,
      input  line_ready, hit_valid, hit, hit_type, hit_u, hit_v, overflow, collide, dbg_state
   );

   modport slave (
      input  gamedata, line_start, line_y, pix_valid, pix_x,
      output line_ready, hit_valid, hit, hit_type, hit_u, hit_v, overflow, collide, dbg_state
   );

endinterface

// File: rtl/gamedata_slot_match.sv
// One buffered object for the current line: holds its fields and tests a pixel column against
// its horizontal extent, producing the local (u,v) sprite coordinates.
module gamedata_slot_match
   import gamedata_line_scanner_pkg::*;
(
   input  logic              clock,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              ld_i,
   input  logic [TYPE_W-1:0] ld_type_i,
   input  logic [X_W-1:0]    ld_x_i,
   input  logic [W_W-1:0]    ld_w_i,
   input  logic [H_W-1:0]    ld_v_i,
   input  logic [X_W-1:0]    pix_x_i,
   output logic              match_o,
   output logic [TYPE_W-1:0] type_o,
   output logic [W_W-1:0]    u_o,
   output logic [H_W-1:0]    v_o
);

   logic              valid_q;
   logic [TYPE_W-1:0] type_q;
   logic [X_W-1:0]    x_q;
   logic [W_W-1:0]    w_q;
   logic [H_W-1:0]    v_q;
   logic [X_W:0]      x_end;

   always_ff @(posedge clock) begin
      if (rst) begin
         valid_q <= 1'b0;
         type_q  <= '0;
         x_q     <= '0;
         w_q     <= '0;
         v_q     <= '0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end else if (ld_i) begin
         valid_q <= 1'b1;
         type_q  <= ld_type_i;
         x_q     <= ld_x_i;
         w_q     <= ld_w_i;
         v_q     <= ld_v_i;
      end
   end

   // Widened end column: objects near the right edge must not wrap back to column 0.
   assign x_end   = {1'b0, x_q} + {{(X_W + 1 - W_W){1'b0}}, w_q};
   assign match_o = valid_q && (pix_x_i >= x_q) && ({1'b0, pix_x_i} < x_end);
   assign type_o  = type_q;
   assign u_o     = pix_x_i[W_W-1:0] - x_q[W_W-1:0];
   assign v_o     = v_q;

endmodule

// File: rtl/gamedata_line_scanner.sv
// Per-line gamedata scanner: snapshots the object list, buffers objects overlapping the line,
// then answers pixel queries with the topmost covering object. Optional: GAMEDATA_COLLIDE_EN.
module gamedata_line_scanner
   import gamedata_line_scanner_pkg::*;
(
   input  logic                   clock,
   input  logic                   rst,
   gamedata_line_scanner_if.slave bus
);

   state_t               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 overflow_q;
   logic                 line_ready_q;
   logic [Y_W-1:0]       line_y_q;
   logic [DATA_LEN-1:0]  snap_q [OBJ_COUNT];

   obj_t                 cur;
   logic                 cur_end;
   logic                 cur_overlap;
   logic                 slot_free;
   logic                 scan_ld;
   logic [H_W-1:0]       cur_v;

   logic                 match   [SLOTS];
   logic [TYPE_W-1:0]    s_type  [SLOTS];
   logic [W_W-1:0]       s_u     [SLOTS];
   logic [H_W-1:0]       s_v     [SLOTS];

   logic                 any_hit;
   logic [TYPE_W-1:0]    sel_type;
   logic [W_W-1:0]       sel_u;
   logic [H_W-1:0]       sel_v;

   logic                 hit_valid_q;
   logic                 hit_q;
   logic [TYPE_W-1:0]    hit_type_q;
   logic [W_W-1:0]       hit_u_q;
   logic [H_W-1:0]       hit_v_q;
   logic                 collide_q;

   assign cur         = obj_t'(snap_q[idx_q]);
   assign cur_end     = (cur.typ == TYPE_END);
   assign cur_overlap = line_overlap(cur, line_y_q);
   assign slot_free   = (cnt_q < CNT_W'(SLOTS));
   assign cur_v       = line_y_q[H_W-1:0] - cur.y[H_W-1:0];
   assign scan_ld     = (state_q == ST_SCAN) && !bus.line_start && !cur_end && cur_overlap && slot_free;

   // Scan FSM. line_start wins over everything and restarts from a fresh snapshot.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         overflow_q   <= 1'b0;
         line_ready_q <= 1'b0;
         line_y_q     <= '0;
         for (int k = 0; k < OBJ_COUNT; k++) snap_q[k] <= '0;
      end else if (bus.line_start) begin
         state_q      <= ST_SCAN;
         idx_q        <= '0;
         cnt_q        <= '0;
         overflow_q   <= 1'b0;
         line_ready_q <= 1'b0;
         line_y_q     <= bus.line_y;
         for (int k = 0; k < OBJ_COUNT; k++) snap_q[k] <= bus.gamedata[k*DATA_LEN +: DATA_LEN];
      end else if (state_q == ST_SCAN) begin
         if (cur_end) begin
            state_q      <= ST_READY;
            line_ready_q <= 1'b1;
         end else begin
            if (cur_overlap) begin
               if (slot_free) cnt_q <= cnt_q + 1'b1;
               else           overflow_q <= 1'b1;
            end
            if (idx_q == IDX_W'(OBJ_COUNT - 1)) begin
               state_q      <= ST_READY;
               line_ready_q <= 1'b1;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      gamedata_slot_match u_slot (
         .clock     (clock),
         .rst       (rst),
         .clr_i     (bus.line_start),
         .ld_i      (scan_ld && (cnt_q == CNT_W'(k))),
         .ld_type_i (cur.typ),
         .ld_x_i    (cur.x),
         .ld_w_i    (cur.w),
         .ld_v_i    (cur_v),
         .pix_x_i   (bus.pix_x),
         .match_o   (match[k]),
         .type_o    (s_type[k]),
         .u_o       (s_u[k]),
         .v_o       (s_v[k])
      );
   end

   // Walk from the top slot down so the lowest matching slot overrides the rest.
   always_comb begin
      any_hit  = 1'b0;
      sel_type = '0;
      sel_u    = '0;
      sel_v    = '0;
      for (int k = SLOTS - 1; k >= 0; k--) begin
         if (match[k]) begin
            any_hit  = 1'b1;
            sel_type = s_type[k];
            sel_u    = s_u[k];
            sel_v    = s_v[k];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         hit_valid_q <= 1'b0;
         hit_q       <= 1'b0;
         hit_type_q  <= '0;
         hit_u_q     <= '0;
         hit_v_q     <= '0;
      end else begin
         hit_valid_q <= bus.pix_valid;
         if (bus.pix_valid) begin
            if (line_ready_q && any_hit) begin
               hit_q      <= 1'b1;
               hit_type_q <= sel_type;
               hit_u_q    <= sel_u;
               hit_v_q    <= sel_v;
            end else begin
               hit_q      <= 1'b0;
               hit_type_q <= '0;
               hit_u_q    <= '0;
               hit_v_q    <= '0;
            end
         end
      end
   end

`ifdef GAMEDATA_COLLIDE_EN
   logic seen_one;
   logic multi_hit;

   always_comb begin
      seen_one  = 1'b0;
      multi_hit = 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
         if (match[k]) begin
            if (seen_one) multi_hit = 1'b1;
            seen_one = 1'b1;
         end
      end
   end

   // Sticky for the whole frame; only the line-0 start of the next frame clears it.
   always_ff @(posedge clock) begin
      if (rst) begin
         collide_q <= 1'b0;
      end else if (bus.pix_valid && line_ready_q && multi_hit) begin
         collide_q <= 1'b1;
      end else if (bus.line_start && (bus.line_y == '0)) begin
         collide_q <= 1'b0;
      end
   end
`else
   assign collide_q = 1'b0;
`endif

   assign bus.line_ready = line_ready_q;
   assign bus.overflow   = overflow_q;
   assign bus.hit_valid  = hit_valid_q;
   assign bus.hit        = hit_q;
   assign bus.hit_type   = hit_type_q;
   assign bus.hit_u      = hit_u_q;
   assign bus.hit_v      = hit_v_q;
   assign bus.collide    = collide_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_gamedata_line_scanner.sv
// Self-checking bench for gamedata_line_scanner: vector table plus hand-written line/reset sequences.
// Checks collide against the GAMEDATA_COLLIDE_EN build setting.
module tb_gamedata_line_scanner;
   import gamedata_line_scanner_pkg::*;

   localparam int EXP_W = 1 + TYPE_W + W_W + H_W;

`ifdef GAMEDATA_COLLIDE_EN
   localparam logic COLL_ON = 1'b1;
`else
   localparam logic COLL_ON = 1'b0;
`endif

   typedef struct {
      int lid;
      int ly;
      int px;
      int hit;
      int t;
      int u;
      int v;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gamedata_line_scanner_if bus ();

   gamedata_line_scanner dut (
      .clock (clk),
      .rst   (rst),
      .bus   (bus)
   );

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [GD_W-1:0]  lists [7];
   vec_t             vecs[$];

   // ---------------- helpers / drivers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_LEN-1:0] mk(int t, int x, int y, int w, int h);
      return {H_W'(h), W_W'(w), Y_W'(y), X_W'(x), TYPE_W'(t)};
   endfunction

   function automatic vec_t vv(int lid, int ly, int px, int hit, int t, int u, int v);
      vec_t r;
      r.lid = lid; r.ly = ly; r.px = px; r.hit = hit; r.t = t; r.u = u; r.v = v;
      return r;
   endfunction

   function automatic logic [EXP_W-1:0] pack_exp(int hit, int t, int u, int v);
      return {1'(hit), TYPE_W'(t), W_W'(u), H_W'(v)};
   endfunction

   // Reference: walk to the terminator, keep the first SLOTS overlapping entries,
   // answer with the first kept entry whose column range covers px.
   function automatic logic [EXP_W-1:0] model(logic [GD_W-1:0] gd, int ly, int px);
      int used;
      logic [DATA_LEN-1:0] e;
      int t, x, y, w, h;
      used = 0;
      for (int i = 0; i < OBJ_COUNT; i++) begin
         e = gd[i*DATA_LEN +: DATA_LEN];
         t = int'(e[TYPE_W-1:0]);
         x = int'(e[TYPE_W +: X_W]);
         y = int'(e[TYPE_W+X_W +: Y_W]);
         w = int'(e[TYPE_W+X_W+Y_W +: W_W]);
         h = int'(e[TYPE_W+X_W+Y_W+W_W +: H_W]);
         if (t == 0) break;
         if (y <= ly && ly < y + h && used < SLOTS) begin
            used++;
            if (x <= px && px < x + w) return pack_exp(1, t, px - x, ly - y);
         end
      end
      return '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic query(input int x, input logic [EXP_W-1:0] e);
      bus.pix_valid = 1'b1;
      bus.pix_x     = X_W'(x);
      exp_q.push_back(e);
      tick();
      bus.pix_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (3) tick();
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Inputs are scrambled right after capture so any snapshot tearing shows up in later queries.
   task automatic start_line(input logic [GD_W-1:0] gd, input int y, output int lat);
      bus.gamedata   = gd;
      bus.line_y     = Y_W'(y);
      bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
      bus.gamedata   = ~gd;
      bus.line_y     = ~Y_W'(y);
      lat = 0;
      while (bus.line_ready !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      if (bus.line_ready !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL line_ready_timeout: got 0 expected 1 after %0d cycles", lat);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.hit_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_hit_valid: got 1 expected 0 at %0t", $time);
         end else begin
            check("query_response", 32'({bus.hit, bus.hit_type, bus.hit_u, bus.hit_v}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int lat;
      int plid, ply;
      logic [GD_W-1:0] rl;

      bus.gamedata   = '0;
      bus.line_start = 1'b0;
      bus.line_y     = '0;
      bus.pix_valid  = 1'b0;
      bus.pix_x      = '0;

      lists = '{default: '0};
      lists[0][0 +: DATA_LEN] = mk(TYPE_DINO, 10, 400, 40, 80);
      lists[1][0 +: DATA_LEN] = mk(TYPE_DINO, 10, 100, 40, 40);
      lists[1][DATA_LEN +: DATA_LEN] = mk(TYPE_OBSTACLE, 30, 100, 40, 40);
      for (int i = 0; i < 6; i++) lists[2][i*DATA_LEN +: DATA_LEN] = mk((i % 3) + 1, i * 50, 0, 40, 100);
      lists[3][0 +: DATA_LEN] = mk(1, 10, 50, 40, 0);
      lists[3][DATA_LEN +: DATA_LEN] = mk(2, 10, 40, 0, 20);
      lists[3][2*DATA_LEN +: DATA_LEN] = mk(3, 100, 40, 10, 20);
      for (int i = 0; i < 8; i++) lists[4][i*DATA_LEN +: DATA_LEN] = mk((i % 3) + 1, i * 40, 0, 30, 100);
      lists[5][0 +: DATA_LEN] = mk(1, 1000, 1000, 40, 60);

      // list, line_y, pix_x, hit, type, u, v
      vecs.push_back(vv(0, 420, 30, 1, 1, 20, 20));
      vecs.push_back(vv(0, 480, 30, 0, 0, 0, 0));
      vecs.push_back(vv(0, 479, 30, 1, 1, 20, 79));
      vecs.push_back(vv(0, 400, 10, 1, 1, 0, 0));
      vecs.push_back(vv(0, 399, 30, 0, 0, 0, 0));
      vecs.push_back(vv(0, 420,  9, 0, 0, 0, 0));
      vecs.push_back(vv(0, 420, 10, 1, 1, 0, 20));
      vecs.push_back(vv(0, 420, 49, 1, 1, 39, 20));
      vecs.push_back(vv(0, 420, 50, 0, 0, 0, 0));
      vecs.push_back(vv(1, 110, 35, 1, 1, 25, 10));
      vecs.push_back(vv(1, 110, 60, 1, 2, 30, 10));
      vecs.push_back(vv(1, 110, 29, 1, 1, 19, 10));
      vecs.push_back(vv(1, 110, 70, 0, 0, 0, 0));
      vecs.push_back(vv(2,  50, 160, 1, 1, 10, 50));
      vecs.push_back(vv(2,  50, 210, 0, 0, 0, 0));
      vecs.push_back(vv(2,  50, 10, 1, 1, 10, 50));
      vecs.push_back(vv(2,  50, 60, 1, 2, 10, 50));
      vecs.push_back(vv(2,  50, 110, 1, 3, 10, 50));
      vecs.push_back(vv(3,  50, 20, 0, 0, 0, 0));
      vecs.push_back(vv(3,  50, 15, 0, 0, 0, 0));
      vecs.push_back(vv(3,  50, 105, 1, 3, 5, 10));
      vecs.push_back(vv(5, 1010, 1010, 1, 1, 10, 10));

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_line_ready", 32'(bus.line_ready), 32'd0);
      check("reset_hit_valid",  32'(bus.hit_valid), 32'd0);
      check("reset_hit_fields", 32'({bus.hit, bus.hit_type, bus.hit_u, bus.hit_v}), 32'd0);
      check("reset_overflow",   32'(bus.overflow), 32'd0);
      check("reset_collide",    32'(bus.collide), 32'd0);
      check("reset_state",      32'(bus.dbg_state), 32'(ST_IDLE));

      // Scan latency on a two-entry list (object + terminator)
      start_line(lists[0], 420, lat);
      check("latency_list1", 32'(lat), 32'd2);
      check("overflow_list1", 32'(bus.overflow), 32'd0);
      check("state_ready", 32'(bus.dbg_state), 32'(ST_READY));

      // Query during SCAN misses; response fields hold once queries stop
      bus.gamedata = lists[0]; bus.line_y = Y_W'(420); bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
      query(30, '0);
      lat = 0;
      while (bus.line_ready !== 1'b1 && lat < 20) begin tick(); lat++; end
      query(30, pack_exp(1, 1, 20, 20));
      tick();
      check("idle_hit_valid_low", 32'(bus.hit_valid), 32'd0);
      check("idle_hit_holds", 32'({bus.hit, bus.hit_type, bus.hit_u, bus.hit_v}), 32'(pack_exp(1, 1, 20, 20)));
      drain();

      // Vector table
      plid = -1; ply = -1;
      foreach (vecs[i]) begin
         if (vecs[i].lid != plid || vecs[i].ly != ply) begin
            start_line(lists[vecs[i].lid], vecs[i].ly, lat);
            plid = vecs[i].lid; ply = vecs[i].ly;
         end
         query(vecs[i].px, pack_exp(vecs[i].hit, vecs[i].t, vecs[i].u, vecs[i].v));
      end
      drain();

      // Slot overflow and full-length scans
      start_line(lists[2], 50, lat);
      check("latency_six_objects", 32'(lat), 32'd7);
      check("overflow_six_objects", 32'(bus.overflow), 32'd1);
      start_line(lists[4], 50, lat);
      check("latency_full_list", 32'(lat), 32'(OBJ_COUNT));
      check("overflow_full_list", 32'(bus.overflow), 32'd1);
      query(150, '0);
      query(100, pack_exp(1, 3, 20, 50));

      // Restart mid-scan: second line_start two cycles after the first
      bus.gamedata = lists[1]; bus.line_y = Y_W'(110); bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
      tick();
      start_line(lists[0], 420, lat);
      check("restart_latency", 32'(lat), 32'd2);
      check("restart_overflow_cleared", 32'(bus.overflow), 32'd0);
      query(60, '0);
      query(30, pack_exp(1, 1, 20, 20));
      drain();

      // Multi-slot hit: sticky collide across lines, cleared at frame start
      start_line(lists[1], 110, lat);
      query(35, pack_exp(1, 1, 25, 10));
      drain();
      check("collide_after_double_hit", 32'(bus.collide), 32'(COLL_ON));
      start_line(lists[1], 200, lat);
      check("collide_sticky", 32'(bus.collide), 32'(COLL_ON));
      start_line(lists[1], 0, lat);
      check("collide_frame_clear", 32'(bus.collide), 32'd0);

      // Random lists against the reference model
      for (int r = 0; r < 4; r++) begin
         int ly;
         rl = '0;
         for (int i = 0; i < OBJ_COUNT; i++) begin
            int t;
            t = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            rl[i*DATA_LEN +: DATA_LEN] = mk(t, $urandom_range(0, 300), $urandom_range(0, 100),
                                            $urandom_range(0, 60), $urandom_range(0, 60));
         end
         ly = $urandom_range(0, 120);
         start_line(rl, ly, lat);
         for (int q = 0; q < 16; q++) begin
            int px;
            px = $urandom_range(0, 380);
            query(px, model(rl, ly, px));
         end
      end
      drain();

      // Reset in the middle of a scan
      start_line(lists[0], 420, lat);
      query(30, pack_exp(1, 1, 20, 20));
      drain();
      bus.gamedata = lists[4]; bus.line_y = Y_W'(50); bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
      tick();
      check("midscan_state", 32'(bus.dbg_state), 32'(ST_SCAN));
      rst = 1'b1;
      tick();
      check("rst_line_ready", 32'(bus.line_ready), 32'd0);
      check("rst_hit_valid", 32'(bus.hit_valid), 32'd0);
      check("rst_hit_fields", 32'({bus.hit, bus.hit_type, bus.hit_u, bus.hit_v}), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_collide", 32'(bus.collide), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      tick();
      query(10, '0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
